// File: rtl/simple_merger_pkg.sv
// Shared constants, state type and helpers for the 4-to-1 packet merger.
package simple_merger_pkg;

  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = 2;

  typedef enum logic {IDLE, BUSY} state_e;

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [PORT_W-1:0] idx);
    return NUM_PORTS'(1) << idx;
  endfunction

endpackage

// File: rtl/simple_merger_if.sv
// Source-side and sink-side handshake bundle of the merger.
interface simple_merger_if #(parameter int WIDTH = 32);
  import simple_merger_pkg::*;

  logic [WIDTH-1:0]     din0;
  logic [WIDTH-1:0]     din1;
  logic [WIDTH-1:0]     din2;
  logic [WIDTH-1:0]     din3;
  logic [NUM_PORTS-1:0] din_valid;
  logic [NUM_PORTS-1:0] din_last;
  logic [NUM_PORTS-1:0] din_ready;
  logic [WIDTH-1:0]     dout;
  logic                 dout_valid;
  logic                 dout_last;
  logic [PORT_W-1:0]    dout_addr;
  logic                 dout_ready;

  // The merger itself.
  modport slave (
    input  din0, din1, din2, din3, din_valid, din_last, dout_ready,
    output din_ready, dout, dout_valid, dout_last, dout_addr
  );

  // Sources and sink driving the merger.
  modport master (
    output din0, din1, din2, din3, din_valid, din_last, dout_ready,
    input  din_ready, dout, dout_valid, dout_last, dout_addr
  );

endinterface

// File: rtl/simple_merger_rr_arbiter4.sv
// Combinational 4-way round-robin arbiter; search starts at ptr+1 and wraps.
module rr_arbiter4
  import simple_merger_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PORT_W-1:0]    gnt_idx,
  output logic                 gnt_any
);

  logic [PORT_W-1:0] cand;

  // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = ptr + PORT_W'(k + 1);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt = gnt_any ? onehot(gnt_idx) : '0;
  end

endmodule

// File: rtl/simple_merger.sv
// 4-to-1 packet merger: round-robin between packets, never interleaving beats,
// with a single registered output entry tagged by source index.
module simple_merger
  import simple_merger_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  simple_merger_if.slave  bus
);

  state_e               state, state_n;
  logic [PORT_W-1:0]    rr_ptr, rr_n;
  logic [PORT_W-1:0]    lock_idx, lock_n;

  logic [NUM_PORTS-1:0] arb_gnt;
  logic [PORT_W-1:0]    arb_idx;
  logic                 arb_any;

  logic                 slot_free;
  logic [NUM_PORTS-1:0] grant;
  logic [PORT_W-1:0]    sel_idx;
  logic                 sel_last;
  logic [WIDTH-1:0]     sel_data;
  logic                 accept;

  rr_arbiter4 u_arb (
    .req     (bus.din_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign slot_free = !bus.dout_valid || bus.dout_ready;
  // While a packet is open only its owner is eligible, valid or not, so a
  // stalled source produces bubbles instead of letting another port in.
  assign grant     = (state == BUSY) ? onehot(lock_idx) : arb_gnt;
  assign sel_idx   = (state == BUSY) ? lock_idx : arb_idx;
  assign bus.din_ready = slot_free ? grant : '0;
  assign accept    = |(bus.din_valid & bus.din_ready);
  assign sel_last  = bus.din_last[sel_idx];

  always_comb begin
    sel_data = '0;
    case (sel_idx)
      2'd0: sel_data = bus.din0;
      2'd1: sel_data = bus.din1;
      2'd2: sel_data = bus.din2;
      2'd3: sel_data = bus.din3;
      default: sel_data = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    lock_n  = lock_idx;
    if (accept) begin
      case (state)
        IDLE: begin
          if (sel_last) begin
            rr_n = sel_idx;
          end else begin
            state_n = BUSY;
            lock_n  = sel_idx;
          end
        end
        BUSY: begin
          if (sel_last) begin
            state_n = IDLE;
            rr_n    = lock_idx;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= 2'd3;
      lock_idx       <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_last  <= 1'b0;
      bus.dout_addr  <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_n;
      lock_idx <= lock_n;
      if (accept) begin
        bus.dout       <= sel_data;
        bus.dout_valid <= 1'b1;
        bus.dout_last  <= sel_last;
        bus.dout_addr  <= sel_idx;
      end else if (slot_free) begin
        bus.dout       <= '0;
        bus.dout_valid <= 1'b0;
        bus.dout_last  <= 1'b0;
        bus.dout_addr  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_simple_merger.sv
// Directed scenarios plus a randomized packet stream checked against a
// packet-level round-robin scoreboard.
module tb_simple_merger;
  import simple_merger_pkg::*;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  simple_merger_if #(.WIDTH(WIDTH)) bus ();

  simple_merger #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic set_port(input int p, input logic [WIDTH-1:0] d,
                          input logic v, input logic l);
    bus.din_valid[p] = v;
    bus.din_last[p]  = l;
    case (p)
      0: bus.din0 = d;
      1: bus.din1 = d;
      2: bus.din2 = d;
      default: bus.din3 = d;
    endcase
  endtask

  task automatic idle_inputs();
    bus.din0 = '0; bus.din1 = '0; bus.din2 = '0; bus.din3 = '0;
    bus.din_valid = '0;
    bus.din_last  = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    bus.dout_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    bus.dout_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.dout, bus.dout_valid, bus.dout_last, bus.dout_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: dout=%h valid=%b last=%b addr=%0d, want all 0",
               bus.dout, bus.dout_valid, bus.dout_last, bus.dout_addr);
    end
    checks++;
    if (bus.din_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_din_ready: got %b want 0000", bus.din_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.din_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: valid=%b din_ready=%b want 0/0000",
               bus.dout_valid, bus.din_ready);
    end
  endtask

  task automatic test_single_beat();
    apply_reset();
    set_port(2, 32'hAA, 1'b1, 1'b1);
    #1;
    checks++;
    if (bus.din_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: got %b want 0100", bus.din_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.dout !== 32'hAA || bus.dout_addr !== 2'd2 || bus.dout_last !== 1'b1 ||
        bus.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_out: dout=%h addr=%0d last=%b valid=%b want aa/2/1/1",
               bus.dout, bus.dout_addr, bus.dout_last, bus.dout_valid);
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({bus.dout, bus.dout_valid, bus.dout_last, bus.dout_addr} !== '0) begin
      errors++;
      $display("FAIL single_drain: dout=%h valid=%b, want all 0", bus.dout, bus.dout_valid);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int p = 0; p < NUM_PORTS; p++) set_port(p, 32'h10 + p, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout_addr !== 2'(k % 4) ||
          bus.dout !== 32'(32'h10 + (k % 4))) begin
        errors++;
        $display("FAIL rr_order[%0d]: valid=%b addr=%0d dout=%h want 1/%0d/%h",
                 k, bus.dout_valid, bus.dout_addr, bus.dout, k % 4, 32'h10 + (k % 4));
      end
    end
    idle_inputs();
  endtask

  task automatic test_packet_lock();
    // per cycle: port1 beat, port0 valid, expected din_ready, expected output
    logic [WIDTH-1:0] p1_d [6] = '{32'hA1, 32'h0, 32'hA2, 32'hA3, 32'h0, 32'h0};
    logic             p1_v [6] = '{1, 0, 1, 1, 0, 0};
    logic             p1_l [6] = '{0, 0, 0, 1, 0, 0};
    logic             p0_v [6] = '{0, 1, 1, 1, 1, 0};
    logic [3:0]       rdy  [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0000};
    logic [WIDTH-1:0] o_d  [6] = '{32'hA1, 32'h0, 32'hA2, 32'hA3, 32'hB0, 32'h0};
    logic             o_v  [6] = '{1, 0, 1, 1, 1, 0};
    logic             o_l  [6] = '{0, 0, 0, 1, 1, 0};
    logic [1:0]       o_a  [6] = '{1, 0, 1, 1, 0, 0};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      set_port(1, p1_d[c], p1_v[c], p1_l[c]);
      set_port(0, 32'hB0, p0_v[c], 1'b1);
      #1;
      checks++;
      if (bus.din_ready !== rdy[c]) begin
        errors++;
        $display("FAIL lock_ready[%0d]: got %b want %b", c, bus.din_ready, rdy[c]);
      end
      @(negedge clk);
      checks++;
      if (bus.dout !== o_d[c] || bus.dout_valid !== o_v[c] || bus.dout_last !== o_l[c] ||
          bus.dout_addr !== o_a[c]) begin
        errors++;
        $display("FAIL lock_out[%0d]: dout=%h v=%b l=%b a=%0d want %h/%b/%b/%0d", c,
                 bus.dout, bus.dout_valid, bus.dout_last, bus.dout_addr,
                 o_d[c], o_v[c], o_l[c], o_a[c]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_port(3, 32'hD0, 1'b1, 1'b1);
    @(negedge clk);
    bus.dout_ready = 1'b0;
    set_port(3, 32'hD1, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.din_ready !== 4'b0000) begin
        errors++;
        $display("FAIL stall_ready[%0d]: got %b want 0000", c, bus.din_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.dout !== 32'hD0 || bus.dout_addr !== 2'd3 || bus.dout_last !== 1'b1 ||
          bus.dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: dout=%h addr=%0d last=%b valid=%b want d0/3/1/1",
                 c, bus.dout, bus.dout_addr, bus.dout_last, bus.dout_valid);
      end
    end
    bus.dout_ready = 1'b1;
    #1;
    checks++;
    if (bus.din_ready !== 4'b1000) begin
      errors++;
      $display("FAIL stall_release_ready: got %b want 1000", bus.din_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.dout !== 32'hD1 || bus.dout_addr !== 2'd3 || bus.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_next: dout=%h addr=%0d valid=%b want d1/3/1",
               bus.dout, bus.dout_addr, bus.dout_valid);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    set_port(1, 32'hC1, 1'b1, 1'b0);
    @(negedge clk);
    set_port(1, 32'hC2, 1'b1, 1'b0);
    set_port(0, 32'hE0, 1'b1, 1'b1);
    @(negedge clk);
    set_port(1, 32'hC3, 1'b1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.dout !== '0) begin
      errors++;
      $display("FAIL midrst_clear: valid=%b dout=%h want 0/0", bus.dout_valid, bus.dout);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.din_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_ready: got %b want 0001", bus.din_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.dout !== 32'hE0 || bus.dout_addr !== 2'd0 || bus.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_first: dout=%h addr=%0d valid=%b want e0/0/1",
               bus.dout, bus.dout_addr, bus.dout_valid);
    end
    idle_inputs();
  endtask

  // Every port always has a packet pending, so the expected stream is whole
  // packets taken from ports 0,1,2,3,0,... regardless of sink stalls.
  task automatic test_random_stream();
    beat_t            src_q [NUM_PORTS][$];
    beat_t            exp_q [$];
    logic [1:0]       exp_a [$];
    beat_t            b;
    int               len;
    int               cyc;
    logic             held;
    logic [WIDTH-1:0] h_d;
    logic [1:0]       h_a;
    logic             h_l;
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) begin
          b.data = $urandom;
          b.last = (i == len - 1);
          src_q[p].push_back(b);
          exp_q.push_back(b);
          exp_a.push_back(2'(p));
        end
      end
    end
    apply_reset();
    held = 1'b0;
    h_d = '0; h_a = '0; h_l = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 2000) begin
      if (held) begin
        checks++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== h_d || bus.dout_addr !== h_a ||
            bus.dout_last !== h_l) begin
          errors++;
          $display("FAIL rand_hold[%0d]: dout=%h addr=%0d last=%b want %h/%0d/%b",
                   cyc, bus.dout, bus.dout_addr, bus.dout_last, h_d, h_a, h_l);
        end
      end
      bus.dout_ready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (src_q[p].size() > 0) set_port(p, src_q[p][0].data, 1'b1, src_q[p][0].last);
        else                     set_port(p, '0, 1'b0, 1'b0);
      end
      #1;
      checks++;
      if ($countones(bus.din_ready) > 1) begin
        errors++;
        $display("FAIL rand_onehot[%0d]: din_ready=%b", cyc, bus.din_ready);
      end
      if (bus.dout_valid && bus.dout_ready) begin
        checks++;
        if (bus.dout !== exp_q[0].data || bus.dout_last !== exp_q[0].last ||
            bus.dout_addr !== exp_a[0]) begin
          errors++;
          $display("FAIL rand_beat[%0d]: dout=%h last=%b addr=%0d want %h/%b/%0d", cyc,
                   bus.dout, bus.dout_last, bus.dout_addr,
                   exp_q[0].data, exp_q[0].last, exp_a[0]);
        end
        void'(exp_q.pop_front());
        void'(exp_a.pop_front());
      end
      for (int p = 0; p < NUM_PORTS; p++)
        if (bus.din_valid[p] && bus.din_ready[p]) void'(src_q[p].pop_front());
      held = bus.dout_valid && !bus.dout_ready;
      h_d  = bus.dout;
      h_a  = bus.dout_addr;
      h_l  = bus.dout_last;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_timeout: %0d beats still expected after %0d cycles",
               exp_q.size(), cyc);
    end
    idle_inputs();
    bus.dout_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.dout_ready = 1'b1;
    test_reset();
    test_single_beat();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
